// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG bias calibrator and its byte packer.
// Holds the controller state encoding, the output byte width and the
// majority threshold used to judge each calibration window.
package trng_pkg;

  // Controller states: IDLE until started, SETTLE/MEASURE/EVAL once per
  // trial bit of the successive-approximation search, RUN afterwards.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_RUN
  } state_t;

  // Width of the assembled random word.
  localparam int BYTE_W = 8;

  // Half of a 2^log2w sample window: a window with more ones than this
  // means the oscillator is biased towards 1 at the current code.
  function automatic int win_half(input int log2w);
    return (1 << log2w) / 2;
  endfunction

endpackage

// File: rtl/trng_bias_ctrl_if.sv
// Random byte stream: byte_data qualified by byte_valid, accepted on byte_ready.
// Producer (master) holds byte_data/byte_valid stable until byte_ready is seen.
// Ports: byte_data[7:0], byte_valid (producer -> consumer), byte_ready (back).
interface trng_bias_ctrl_if;
  import trng_pkg::*;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/trng_byte_packer.sv
// Packs accepted oscillator bits LSB-first into bytes on a valid/ready stream.
// Latency: byte_valid rises the cycle after the 8th accepted bit.
// Backpressure: a byte completing while the held byte is unaccepted is dropped
// and the sticky overrun flag is set; assembly never stalls.
// Ports: clk, rst (sync, active-high), clr (drop partial byte, valid and
// overrun), smp_vld/smp (raw sample stream), byte_if (master), overrun.
// Build option TRNG_VN_EN: Von Neumann corrector on non-overlapping sample
// pairs (01 -> 0, 10 -> 1, 00/11 discarded); otherwise every sample is used.
module trng_byte_packer
  import trng_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             smp_vld,
  input  logic             smp,
  trng_bias_ctrl_if.master byte_if,
  output logic             overrun
);

  localparam int CNT_W = $clog2(BYTE_W);

  logic [BYTE_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              acc_vld;
  logic              acc_bit;
  logic [BYTE_W-1:0] assembled;
  logic              complete;
  logic              xfer;

`ifdef TRNG_VN_EN
  // First sample of the current pair, held until its partner arrives.
  logic pend;
  logic first;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pend  <= 1'b0;
      first <= 1'b0;
    end else if (smp_vld) begin
      if (!pend) begin
        first <= smp;
        pend  <= 1'b1;
      end else begin
        pend  <= 1'b0;
      end
    end
  end

  // Only an unequal pair yields a bit, and its value is the first sample.
  assign acc_vld = smp_vld && pend && (first != smp);
  assign acc_bit = first;
`else
  assign acc_vld = smp_vld;
  assign acc_bit = smp;
`endif

  // New bits enter at the top so the first bit ends up in bit 0.
  assign assembled = {acc_bit, shreg[BYTE_W-1:1]};
  assign complete  = acc_vld && (bit_cnt == CNT_W'(BYTE_W - 1));
  assign xfer      = byte_if.byte_valid && byte_if.byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg              <= '0;
      bit_cnt            <= '0;
      byte_if.byte_data  <= '0;
      byte_if.byte_valid <= 1'b0;
      overrun            <= 1'b0;
    end else if (clr) begin
      shreg              <= '0;
      bit_cnt            <= '0;
      byte_if.byte_valid <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      if (acc_vld) begin
        shreg   <= assembled;
        bit_cnt <= bit_cnt + 1'b1;  // wraps to 0 after the 8th bit
      end
      // The output slot is free if empty or being emptied this cycle, so a
      // completion coinciding with a transfer is loaded, not dropped.
      if (complete && (!byte_if.byte_valid || byte_if.byte_ready)) begin
        byte_if.byte_data  <= assembled;
        byte_if.byte_valid <= 1'b1;
      end else if (xfer) begin
        byte_if.byte_valid <= 1'b0;
      end
      if (complete && byte_if.byte_valid && !byte_if.byte_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/trng_bias_ctrl.sv
// TRNG bias calibrator: successive-approximation search of the VDAC code that
// balances the oscillator, then streams random bytes through the packer.
// Latency: BITWIDTH*(SETTLE_CYC+2^WIN_LOG2+1) cycles from start to RUN.
// Backpressure: handled by the packer (drop + sticky overrun), FSM never stalls.
// Ports: clk, rst (sync, active-high), start, rnd_bit, dac_code, dac_en,
// busy, cal_done, overrun, byte_if (master: byte_data/byte_valid/byte_ready).
// Build option TRNG_VN_EN: enables the Von Neumann corrector in the packer.
module trng_bias_ctrl
  import trng_pkg::*;
#(
  parameter int BITWIDTH   = 8,
  parameter int WIN_LOG2   = 8,
  parameter int SETTLE_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                rnd_bit,
  output logic [BITWIDTH-1:0] dac_code,
  output logic                dac_en,
  output logic                busy,
  output logic                cal_done,
  output logic                overrun,
  trng_bias_ctrl_if.master    byte_if
);

  localparam int W     = 1 << WIN_LOG2;
  localparam int CMAX  = (SETTLE_CYC > W) ? SETTLE_CYC : W;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int K_W   = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]    MEAS_LAST   = CNT_W'(W - 1);
  localparam logic [WIN_LOG2:0]   HALF        = (WIN_LOG2 + 1)'(win_half(WIN_LOG2));
  localparam logic [BITWIDTH-1:0] MSB_CODE    = BITWIDTH'(1) << (BITWIDTH - 1);

  state_t              state, state_nxt;
  logic [BITWIDTH-1:0] code_nxt;
  logic [K_W-1:0]      k, k_nxt;          // bit currently on trial
  logic [CNT_W-1:0]    cnt, cnt_nxt;      // settle / window cycle counter
  logic [WIN_LOG2:0]   ones, ones_nxt;    // one extra bit: W ones never wrap
  logic                cal_done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dac_code <= '0;
      k        <= '0;
      cnt      <= '0;
      ones     <= '0;
      cal_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      dac_code <= code_nxt;
      k        <= k_nxt;
      cnt      <= cnt_nxt;
      ones     <= ones_nxt;
      cal_done <= cal_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    code_nxt     = dac_code;
    k_nxt        = k;
    cnt_nxt      = cnt;
    ones_nxt     = ones;
    cal_done_nxt = cal_done;
    busy         = 1'b0;
    dac_en       = 1'b1;

    case (state)
      ST_IDLE, ST_RUN: begin
        dac_en = (state == ST_RUN);
        if (start) begin
          state_nxt    = ST_SETTLE;
          code_nxt     = MSB_CODE;
          k_nxt        = K_W'(BITWIDTH - 1);
          cnt_nxt      = '0;
          cal_done_nxt = 1'b0;
        end
      end

      ST_SETTLE: begin
        busy = 1'b1;
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          ones_nxt  = '0;
          state_nxt = ST_MEASURE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_MEASURE: begin
        busy     = 1'b1;
        ones_nxt = ones + (WIN_LOG2 + 1)'(rnd_bit);
        if (cnt == MEAS_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_EVAL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_EVAL: begin
        busy = 1'b1;
        // Too many ones: code is above the balance point, drop this bit.
        // A tie keeps it.
        if (ones > HALF) begin
          code_nxt[k] = 1'b0;
        end
        if (k != '0) begin
          code_nxt[k - 1'b1] = 1'b1;
          k_nxt              = k - 1'b1;
          state_nxt          = ST_SETTLE;
        end else begin
          state_nxt    = ST_RUN;
          cal_done_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Start while busy is ignored, so only a RUN-state start flushes the packer.
  logic pk_clr;
  logic pk_smp_vld;

  assign pk_clr     = start && (state == ST_RUN);
  assign pk_smp_vld = (state == ST_RUN);

  trng_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (pk_clr),
    .smp_vld (pk_smp_vld),
    .smp     (rnd_bit),
    .byte_if (byte_if),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_trng_bias_ctrl.sv
// Bench for trng_bias_ctrl (BITWIDTH=8, WIN_LOG2=4, SETTLE_CYC=4): directed
// calibration/byte sequences plus a randomized RUN phase against a
// queue-based reference model. Works with or without TRNG_VN_EN.
module tb_trng_bias_ctrl;

  localparam int BW     = 8;
  localparam int WL     = 4;
  localparam int SC     = 4;
  localparam int W      = 1 << WL;
  localparam int STEP   = SC + W + 1;
  localparam int CALCYC = BW * STEP;
  localparam logic [7:0] THR = 8'h5A;

`ifdef TRNG_VN_EN
  localparam int NDIR = 22;
  localparam int DONE = 19;
  localparam logic [7:0] DIR_EXP = 8'h06;
  bit dir_smp [0:NDIR-1] = '{0,1, 0,0, 1,0, 1,1, 1,0, 0,1, 0,1, 0,1, 0,1, 0,1, 0,1};
`else
  localparam int NDIR = 8;
  localparam int DONE = 7;
  localparam logic [7:0] DIR_EXP = 8'h4D;
  bit dir_smp [0:NDIR-1] = '{1,0,1,1,0,0,1,0};
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic          rnd_bit;
  logic [BW-1:0] dac_code;
  logic          dac_en;
  logic          busy;
  logic          cal_done;
  logic          overrun;
  logic          cal_mode;
  logic          rnd_drv;

  trng_bias_ctrl_if bif ();

  trng_bias_ctrl #(.BITWIDTH(BW), .WIN_LOG2(WL), .SETTLE_CYC(SC)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rnd_bit  (rnd_bit),
    .dac_code (dac_code),
    .dac_en   (dac_en),
    .busy     (busy),
    .cal_done (cal_done),
    .overrun  (overrun),
    .byte_if  (bif)
  );

  // Oscillator model during calibration: output is 1 above the balance code.
  assign rnd_bit = cal_mode ? (dac_code >= THR) : rnd_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [7:0] trial [0:BW-1];
  logic [7:0] m_final;
  logic       m_run;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovr;
  logic       m_pend;
  logic       m_first;
  bit         m_bits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Binary search over the threshold oscillator: a code at or above THR
  // gives a full window of ones (> half), so that bit is dropped.
  task automatic build_trials();
    logic [7:0] code;
    int ones;
    code = '0;
    for (int j = 0; j < BW; j++) begin
      code = code | (8'h01 << (BW - 1 - j));
      trial[j] = code;
      ones = (code >= THR) ? W : 0;
      if (ones > W / 2) code = code & ~(8'h01 << (BW - 1 - j));
    end
    m_final = code;
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ovr   = 1'b0;
    m_pend  = 1'b0;
    m_first = 1'b0;
    m_bits.delete();
  endtask

  // One clock of the byte stream given the inputs applied before the edge.
  task automatic model_tick(input logic smp, input logic rdy, input logic st);
    logic acc, b, loaded, xfer;
    logic [7:0] nb;
    if (st) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_pend  = 1'b0;
      m_bits.delete();
      return;
    end
    xfer   = m_valid && rdy;
    acc    = 1'b0;
    b      = 1'b0;
    loaded = 1'b0;
    if (m_run) begin
`ifdef TRNG_VN_EN
      if (!m_pend) begin
        m_first = smp;
        m_pend  = 1'b1;
      end else begin
        m_pend = 1'b0;
        if (m_first != smp) begin
          acc = 1'b1;
          b   = m_first;
        end
      end
`else
      acc = 1'b1;
      b   = smp;
`endif
    end
    if (acc) begin
      m_bits.push_back(b);
      if (m_bits.size() == 8) begin
        nb = '0;
        for (int i = 0; i < 8; i++) nb[i] = m_bits[i];
        m_bits.delete();
        if (!m_valid || rdy) begin
          m_data  = nb;
          m_valid = 1'b1;
          loaded  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    if (xfer && !loaded) m_valid = 1'b0;
  endtask

  // One RUN-state cycle: apply inputs, advance model, compare after the edge.
  task automatic cyc(input logic smp, input logic rdy);
    rnd_drv        = smp;
    bif.byte_ready = rdy;
    model_tick(smp, rdy, 1'b0);
    @(posedge clk); #1;
    chk("run_busy",     busy,           0);
    chk("run_dac_en",   dac_en,         1);
    chk("run_cal_done", cal_done,       1);
    chk("run_dac_code", dac_code,       m_final);
    chk("run_valid",    bif.byte_valid, m_valid);
    chk("run_data",     bif.byte_data,  m_data);
    chk("run_overrun",  overrun,        m_ovr);
  endtask

  task automatic feed_bit(input logic b, input logic rdy);
`ifdef TRNG_VN_EN
    cyc(b, rdy);
    cyc(~b, rdy);
`else
    cyc(b, rdy);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dac_code"}, dac_code,       0);
    chk({tag, "_dac_en"},   dac_en,         0);
    chk({tag, "_busy"},     busy,           0);
    chk({tag, "_cal_done"}, cal_done,       0);
    chk({tag, "_data"},     bif.byte_data,  0);
    chk({tag, "_valid"},    bif.byte_valid, 0);
    chk({tag, "_overrun"},  overrun,        0);
  endtask

  // Pulse start and follow a calibration; abort_at >= 0 applies reset
  // (together with start) at that cycle offset instead of finishing.
  task automatic calibrate(input int abort_at);
    cal_mode = 1'b1;
    start    = 1'b1;
    model_tick(1'b0, bif.byte_ready, 1'b1);
    m_run = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < CALCYC; t++) begin
      start = 1'b0;
      if (t == abort_at) begin
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        model_reset();
        check_reset_vals("abort");
        return;
      end
      chk("cal_busy",     busy,           1);
      chk("cal_dac_en",   dac_en,         1);
      chk("cal_done_low", cal_done,       0);
      chk("cal_valid",    bif.byte_valid, m_valid);
      chk("cal_overrun",  overrun,        m_ovr);
      if (t % STEP == 0) chk("cal_trial", dac_code, trial[t / STEP]);
      if (t == 30) start = 1'b1;  // must be ignored while busy
      @(posedge clk); #1;
    end
    chk("cal_end_busy",  busy,     0);
    chk("cal_end_done",  cal_done, 1);
    chk("cal_end_code",  dac_code, m_final);
    chk("cal_code_59",   dac_code, 8'h59);
    cal_mode = 1'b0;
    m_run    = 1'b1;
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    cal_mode       = 1'b0;
    rnd_drv        = 1'b0;
    bif.byte_ready = 1'b0;
    model_reset();
    build_trials();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // Full calibration from IDLE, with an ignored start while busy.
    calibrate(-1);

    // Directed byte; trailing samples with ready low keep the byte held.
    for (int i = 0; i < NDIR; i++) begin
      cyc(dir_smp[i], (i <= DONE) ? 1'b1 : 1'b0);
      if (i == DONE) begin
        chk("dir_valid", bif.byte_valid, 1);
        chk("dir_data",  bif.byte_data,  DIR_EXP);
      end
    end

    // Start in RUN while a byte is pending: flushes it and recalibrates.
    chk("pre_start_valid", bif.byte_valid, 1);
    bif.byte_ready = 1'b0;
    calibrate(-1);

    // Backpressure: two bytes with ready low, second one is dropped.
    for (int i = 0; i < 8; i++) feed_bit(8'hA5 >> i, 1'b0);
    chk("bp_first_valid", bif.byte_valid, 1);
    chk("bp_first_data",  bif.byte_data,  8'hA5);
    chk("bp_no_ovr_yet",  overrun,        0);
    for (int i = 0; i < 8; i++) feed_bit(8'h3C >> i, 1'b0);
    chk("bp_held_data",   bif.byte_data,  8'hA5);
    chk("bp_overrun",     overrun,        1);

    // A later start clears overrun.
    calibrate(-1);
    chk("ovr_cleared", overrun, 0);

    // Randomized RUN traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    // Reset during MEASURE of bit 5, with start asserted alongside.
    calibrate(2 * STEP + SC + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
